// File: rtl/regfile_sb.sv
// Integer register file with NRP combinational read ports, write-to-read bypass,
// one write port and an integrated per-register busy scoreboard with a live count.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 3,
  localparam int AW  = $clog2(NREG),
  localparam int CW  = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                wr_en,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [CW-1:0]       busy_cnt,
  output logic                any_busy
);

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [NREG-1:1] busy_q;
  logic [NREG-1:0] busy_full;
  logic            wr_live;
  logic            iss_live;
  logic            set_eff;
  logic            clr_eff;

  assign busy_full = {busy_q, 1'b0};
  assign wr_live   = wr_en && (waddr != '0);
  assign iss_live  = iss_en && (iss_addr != '0);

  // Count tracks popcount(busy) incrementally; a clear on the register being
  // issued this cycle is not a clear at all, since the set wins.
  assign set_eff = iss_live && !busy_full[iss_addr];
  assign clr_eff = wr_live && busy_full[waddr] && !(iss_live && (iss_addr == waddr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 1; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++)
        if (wr_en && (waddr == AW'(r))) regs[r] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (iss_en && (iss_addr == AW'(r)))
          busy_q[r] <= 1'b1;
        else if (wr_en && (waddr == AW'(r)))
          busy_q[r] <= 1'b0;
      end
      if (set_eff && !clr_eff)
        busy_cnt <= busy_cnt + CW'(1);
      else if (clr_eff && !set_eff)
        busy_cnt <= busy_cnt - CW'(1);
    end
  end

  assign any_busy = (busy_cnt != '0);

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      if (!rst && (raddr[p*AW +: AW] != '0)) begin
        if (wr_en && (waddr == raddr[p*AW +: AW])) begin
          rdata[p*XLEN +: XLEN] = wdata;
        end else begin
          rdata[p*XLEN +: XLEN] = regs[raddr[p*AW +: AW]];
          rbusy[p]              = busy_full[raddr[p*AW +: AW]];
        end
      end
    end
  end

endmodule
